// File: rtl/dds_phase_accum.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | dds_phase_accum                                                         |
// | Phase accumulator and quarter-wave ROM address generator for the DDS.   |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module dds_phase_accum #(
   parameter int                   ACC_WIDTH = 24,
   parameter int                   ROM_WIDTH = 8,
   parameter int                   CE_DIV    = 256,
   parameter logic [ACC_WIDTH-1:0] TW_RESET  = ACC_WIDTH'('h4000)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_en,
   input  logic [ACC_WIDTH-1:0] i_tw,
   input  logic                 i_tw_valid,
   output logic                 o_tw_ready,
   output logic                 o_ce,
   output logic [ROM_WIDTH-1:0] o_addr,
   output logic                 o_mirror,
   output logic                 o_negate,
   output logic                 o_wrap
);

   localparam int                 c_div_w    = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
   localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CE_DIV - 1);

   logic [ACC_WIDTH-1:0] r_acc;
   logic [ACC_WIDTH-1:0] r_tw_act;
   logic [ACC_WIDTH-1:0] r_pend;
   logic                 r_pend_full;
   logic [c_div_w-1:0]   r_div_cnt;

   logic                 w_tick;
   logic                 w_capture;
   logic [ACC_WIDTH:0]   w_sum;
   logic [1:0]           w_quad;
   logic [ROM_WIDTH-1:0] w_idx;

   assign w_tick    = i_en && (r_div_cnt == c_div_last);
   assign w_capture = i_tw_valid && o_tw_ready;
   assign w_sum     = {1'b0, r_acc} + {1'b0, r_tw_act};
   assign w_quad    = w_sum[ACC_WIDTH-1 -: 2];
   assign w_idx     = w_sum[ACC_WIDTH-3 -: ROM_WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc       <= '0;
         r_tw_act    <= TW_RESET;
         r_pend      <= '0;
         r_pend_full <= 1'b0;
         r_div_cnt   <= '0;
         o_tw_ready  <= 1'b1;
         o_ce        <= 1'b0;
         o_addr      <= '0;
         o_mirror    <= 1'b0;
         o_negate    <= 1'b0;
         o_wrap      <= 1'b0;
      end else begin
         if (i_en) begin
            r_div_cnt <= (r_div_cnt == c_div_last) ? '0 : r_div_cnt + 1'b1;
         end

         o_ce <= w_tick;
         if (w_tick) begin
            r_acc    <= w_sum[ACC_WIDTH-1:0];
            o_addr   <= w_quad[0] ? ~w_idx : w_idx;
            o_mirror <= w_quad[0];
            o_negate <= w_quad[1];
            o_wrap   <= w_sum[ACC_WIDTH];
         end

         // A capture needs an empty slot, so it can never collide with the apply branch.
         if (w_tick && r_pend_full) begin
            r_tw_act    <= r_pend;
            r_pend_full <= 1'b0;
            o_tw_ready  <= 1'b1;
         end else if (w_capture) begin
            r_pend      <= i_tw;
            r_pend_full <= 1'b1;
            o_tw_ready  <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dds_phase_accum.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_dds_phase_accum                                                      |
// | Drives a CE_DIV=4 and a CE_DIV=1 instance against an arithmetic model.  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tb_dds_phase_accum;

   localparam logic [23:0] c_tw_reset = 24'h4000;
   localparam longint      c_mod      = 64'd16777216;   // 2^24
   localparam longint      c_quarter  = 64'd4194304;    // 2^22
   localparam longint      c_step     = 64'd16384;      // 2^14 phase units per address

   logic        clk = 1'b0;
   logic        rst;
   logic        i_en;
   logic        i_tw_valid;
   logic [23:0] i_tw;

   logic        g_ce  [2];
   logic        g_rdy [2];
   logic        g_mir [2];
   logic        g_neg [2];
   logic        g_wrap[2];
   logic [7:0]  g_addr[2];

   dds_phase_accum #(.ACC_WIDTH(24), .ROM_WIDTH(8), .CE_DIV(4), .TW_RESET(c_tw_reset)) dut4 (
      .clk(clk), .rst(rst), .i_en(i_en), .i_tw(i_tw), .i_tw_valid(i_tw_valid),
      .o_tw_ready(g_rdy[0]), .o_ce(g_ce[0]), .o_addr(g_addr[0]),
      .o_mirror(g_mir[0]), .o_negate(g_neg[0]), .o_wrap(g_wrap[0])
   );

   dds_phase_accum #(.ACC_WIDTH(24), .ROM_WIDTH(8), .CE_DIV(1), .TW_RESET(c_tw_reset)) dut1 (
      .clk(clk), .rst(rst), .i_en(i_en), .i_tw(i_tw), .i_tw_valid(i_tw_valid),
      .o_tw_ready(g_rdy[1]), .o_ce(g_ce[1]), .o_addr(g_addr[1]),
      .o_mirror(g_mir[1]), .o_negate(g_neg[1]), .o_wrap(g_wrap[1])
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: phase as a plain integer, enabled-edge count modulo the divide ratio.
   int     divs[2] = '{4, 1};
   longint m_acc[2], m_tw[2], m_pend[2];
   int     m_div[2];
   bit     m_pf[2];
   bit     e_ce[2], e_mir[2], e_neg[2], e_wrap[2];
   int     e_addr[2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input int k);
      bit     tick, cap;
      longint sum, quad, idx;
      if (rst) begin
         m_acc[k] = 0; m_tw[k] = longint'(c_tw_reset); m_pf[k] = 0; m_div[k] = 0;
         e_ce[k] = 0; e_addr[k] = 0; e_mir[k] = 0; e_neg[k] = 0; e_wrap[k] = 0;
      end else begin
         tick = i_en && (m_div[k] == divs[k] - 1);
         cap  = i_tw_valid && !m_pf[k];
         if (i_en) m_div[k] = (m_div[k] + 1) % divs[k];
         e_ce[k] = tick;
         if (tick) begin
            sum       = m_acc[k] + m_tw[k];
            e_wrap[k] = (sum >= c_mod);
            m_acc[k]  = sum % c_mod;
            quad      = m_acc[k] / c_quarter;
            idx       = (m_acc[k] % c_quarter) / c_step;
            e_mir[k]  = (quad % 2) == 1;
            e_neg[k]  = quad >= 2;
            e_addr[k] = e_mir[k] ? int'(255 - idx) : int'(idx);
            if (m_pf[k]) begin
               m_tw[k] = m_pend[k];
               m_pf[k] = 0;
            end
         end
         if (cap) begin
            m_pend[k] = longint'(i_tw);
            m_pf[k]   = 1;
         end
      end
   endtask

   task automatic compare(input int k);
      check($sformatf("ce[%0d]", k),     32'(g_ce[k]),   32'(e_ce[k]));
      check($sformatf("ready[%0d]", k),  32'(g_rdy[k]),  32'(!m_pf[k]));
      check($sformatf("addr[%0d]", k),   32'(g_addr[k]), 32'(e_addr[k]));
      check($sformatf("mirror[%0d]", k), 32'(g_mir[k]),  32'(e_mir[k]));
      check($sformatf("negate[%0d]", k), 32'(g_neg[k]),  32'(e_neg[k]));
      if (e_ce[k]) check($sformatf("wrap[%0d]", k), 32'(g_wrap[k]), 32'(e_wrap[k]));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      compare(0);
      compare(1);
   endtask

   task automatic load_tw(input logic [23:0] tw);
      int n = 0;
      while (!g_rdy[0] && n < 20) begin
         cycle();
         n++;
      end
      check("load_wait_ready", 32'(g_rdy[0]), 32'd1);
      i_tw_valid = 1'b1;
      i_tw       = tw;
      cycle();
      i_tw_valid = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1; i_en = 1'b0; i_tw_valid = 1'b0; i_tw = '0;

      // Reset with enable low; handshake traffic must be ignored while in reset.
      repeat (20) begin
         i_tw_valid = 1'($urandom_range(0, 1));
         i_tw       = 24'($urandom);
         cycle();
      end
      i_tw_valid = 1'b0;

      // Release and measure first-strobe latency, then run the full address ramp.
      rst = 1'b0; i_en = 1'b1;
      n = 0;
      while (!g_ce[0] && n < 20) begin
         cycle();
         n++;
      end
      check("first_ce_cycles", 32'(n), 32'd4);
      repeat (1100) cycle();

      // Quarter-turn per sample walks through all four quadrants.
      load_tw(24'h400000);
      repeat (40) cycle();

      // Second word offered while the slot is full must be dropped.
      i_tw_valid = 1'b1; i_tw = 24'h1000;
      cycle();
      i_tw = 24'h2000;
      repeat (2) cycle();
      i_tw_valid = 1'b0;
      repeat (12) cycle();

      // Offer a word exactly on a tick edge of the divided instance.
      n = 0;
      while (m_div[0] != 3 && n < 8) begin
         cycle();
         n++;
      end
      i_tw_valid = 1'b1; i_tw = 24'h3000;
      cycle();
      i_tw_valid = 1'b0;
      repeat (12) cycle();

      // Freeze, resume, then reset in the middle of a run.
      i_en = 1'b0;
      repeat (10) cycle();
      i_en = 1'b1;
      repeat (21) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      repeat (12) cycle();

      // Zero tuning word: strobes continue, outputs stay put.
      load_tw(24'h0);
      repeat (16) cycle();

      // Random traffic.
      repeat (3000) begin
         rst        = ($urandom_range(0, 299) == 0);
         i_en       = ($urandom_range(0, 7) != 0);
         i_tw_valid = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 3))
            0:       i_tw = 24'h0;
            1:       i_tw = 24'($urandom);
            2:       i_tw = 24'($urandom_range(0, 32'hFFFF));
            default: i_tw = 24'hFFFFFF;
         endcase
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
